// File: rtl/mproc_mem_pkg.sv
// Shared definitions for the mproc program memory and loader.
package mproc_mem_pkg;

  // Loader / run states. The encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    LOAD_LO = 2'b00,
    LOAD_HI = 2'b01,
    RUN     = 2'b10
  } state_t;

  localparam int DEFAULT_DEPTH = 128;
  localparam int DEFAULT_AW    = 7;

endpackage

// File: rtl/mproc_mem_mem_array.sv
// DEPTH x 16 storage: one synchronous write port, one asynchronous read port.
// There is deliberately no reset, so a program survives a loader reset.
module mem_array #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];

  // Write port: one word per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: combinational, zero-cycle latency.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/mproc_mem.sv
// Program memory for mproc with a byte-serial host loader.
// Handshake: a byte transfers on a rising edge where ld_valid & ld_ready are
// both high; ld_ready depends only on registered state, never on ld_valid.
// Bytes arrive low byte first; each high byte completes and writes one word.
module mproc_mem
  import mproc_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  output logic [15:0]   mem_dout,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  input  logic          ld_start,
  output logic          cpu_reset,
  output logic          run,
  output logic [AW:0]   words_loaded,
  output logic          ld_err,
  output logic [1:0]    dbg_state
);

  localparam logic [AW:0]   WORDS_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] WPTR_LAST  = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_words;
  logic [7:0]    r_lo;
  logic          r_err;
  logic          w_hs;
  logic          w_we;
  logic [15:0]   w_wdata;
  logic [15:0]   w_rdata;

  // Outputs decoded straight from the state register: glitch free, no latency.
  always_comb begin
    ld_ready     = (r_state == LOAD_LO) || (r_state == LOAD_HI);
    run          = (r_state == RUN);
    cpu_reset    = ~run;
    mem_dout     = run ? w_rdata : 16'h0000;
    words_loaded = r_words;
    ld_err       = r_err;
    dbg_state    = r_state;
  end

  // Next-state logic and the write strobe; reset suppresses any write.
  always_comb begin
    w_hs         = ld_valid & ld_ready;
    w_next_state = r_state;
    w_we         = 1'b0;
    w_wdata      = {ld_byte, r_lo};
    case (r_state)
      LOAD_LO: begin
        if (w_hs) w_next_state = LOAD_HI;
      end
      LOAD_HI: begin
        if (w_hs) begin
          w_we         = ~reset;
          w_next_state = ld_last ? RUN : LOAD_LO;
        end
      end
      RUN: begin
        if (ld_start) w_next_state = LOAD_LO;
      end
      default: w_next_state = LOAD_LO;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD_LO;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Loader datapath: low-byte latch, write pointer, word count, error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo    <= 8'h00;
      r_wptr  <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        LOAD_LO: begin
          if (w_hs) begin
            r_lo <= ld_byte;
            // A program cannot end on a low byte; flag it but keep loading.
            if (ld_last) r_err <= 1'b1;
          end
        end
        LOAD_HI: begin
          if (w_hs) begin
            r_wptr <= (r_wptr == WPTR_LAST) ? '0 : r_wptr + 1'b1;
            if (r_words != WORDS_FULL) r_words <= r_words + 1'b1;
          end
        end
        RUN: begin
          if (ld_start) begin
            r_wptr  <= '0;
            r_words <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (addr),
    .o_rdata (w_rdata)
  );

endmodule
